multicycle_control: RTL

- FSM-based control unit for the 9-bit ISA; successor to the single-cycle combinational decoder.
- Latches one instruction per handshake and sequences the datapath control lines across one or more cycles.
- Handles variable-latency memory with a req/ack handshake and timeout, plus a parametrised multi-cycle multiply.
- Sits between the fetch stage (instr/instr_valid/instr_ready) and the datapath (reg file, ALU, data memory, PC).

---
 rtl/multicycle_control.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle control unit for the 9-bit ISA: latches one instruction per
// handshake and sequences datapath controls through EXEC/MUL/MEM/WB states.
module multicycle_control #(
  parameter int unsigned MCODEBITS   = 9,
  parameter int unsigned OPWIDTH     = 4,
  parameter int unsigned MUL_CYCLES  = 3,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MCODEBITS-1:0] instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 RegDst,
  output logic                 Branch,
  output logic                 MemtoReg,
  output logic                 MemWrite,
  output logic                 ALUSrc,
  output logic                 RegWrite,
  output logic [OPWIDTH-1:0]   ALUOp,
  output logic                 pc_en,
  output logic                 illegal_op,
  output logic                 mem_err
);

  localparam int unsigned MUL_W = $clog2(MUL_CYCLES + 1);
  localparam int unsigned MEM_W = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned MAX_W = (MUL_W > MEM_W) ? MUL_W : MEM_W;
  localparam int unsigned CNT_W = (MAX_W > 0) ? MAX_W : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_ILL, S_MUL, S_MEM, S_WB, S_ABORT
  } state_e;

  state_e               state_q, state_d;
  logic [MCODEBITS-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic               ready_q, req_q, branch_q, m2r_q, mw_q, asrc_q, rw_q;
  logic               pc_q, ill_q, err_q;
  logic [OPWIDTH-1:0] aluop_q;
  logic               ready_d, req_d, branch_d, m2r_d, mw_d, asrc_d, rw_d;
  logic               pc_d, ill_d, err_d;
  logic [OPWIDTH-1:0] aluop_d;

  logic [2:0]         opcode;
  logic [1:0]         funct;
  state_e             dec_tgt;
  logic [OPWIDTH-1:0] dec_aluop;
  logic               dec_alusrc, dec_branch, dec_store;
  logic               accept;
  logic               unused_ir_bits;

  assign accept = (state_q == S_IDLE) && instr_valid;
  assign ir_d   = accept ? instr : ir_q;
  assign opcode = ir_d[MCODEBITS-1 -: 3];
  assign funct  = ir_d[MCODEBITS-4 -: 2];
  assign unused_ir_bits = ^ir_q[MCODEBITS-6:0];

  // Instruction decode: target state and the controls it carries
  always_comb begin
    dec_tgt    = S_EXEC;
    dec_aluop  = '1;
    dec_alusrc = 1'b0;
    dec_branch = 1'b0;
    dec_store  = 1'b0;
    case (opcode)
      3'b000: begin
        if (funct[1]) dec_tgt = S_ILL;
        else          dec_aluop = OPWIDTH'(funct[0]);
      end
      3'b001: begin
        dec_tgt = S_MEM; dec_alusrc = 1'b1; dec_aluop = '0;
      end
      3'b010: begin
        dec_tgt = S_MEM; dec_alusrc = 1'b1; dec_aluop = '0; dec_store = 1'b1;
      end
      3'b011: begin
        dec_alusrc = 1'b1; dec_aluop = '0;
      end
      3'b100: dec_branch = 1'b1;
      3'b101: dec_aluop = '1;
      3'b110: dec_aluop = OPWIDTH'(2) + OPWIDTH'(funct);
      default: begin
        case (funct)
          2'b00:   dec_aluop = OPWIDTH'(6);
          2'b01:   dec_aluop = OPWIDTH'(7);
          2'b10:   begin dec_tgt = S_MUL; dec_aluop = OPWIDTH'(8); end
          default: dec_tgt = S_ILL;
        endcase
      end
    endcase
  end

  // Next state and counters
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          state_d = dec_tgt;
          cnt_d   = (dec_tgt == S_MUL) ? CNT_W'(MUL_CYCLES - 1) : '0;
        end
      end
      S_MUL: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_MEM: begin
        if (mem_ack) begin
          state_d = dec_store ? S_IDLE : S_WB;
          cnt_d   = '0;
        end else if ((MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT - 1))) begin
          state_d = S_ABORT;
          cnt_d   = '0;
        end else if (MEM_TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the state being entered, registered below
  always_comb begin
    ready_d  = (state_d == S_IDLE);
    req_d    = 1'b0;
    branch_d = 1'b0;
    m2r_d    = 1'b0;
    mw_d     = 1'b0;
    asrc_d   = 1'b0;
    rw_d     = 1'b0;
    aluop_d  = '1;
    pc_d     = 1'b0;
    ill_d    = 1'b0;
    err_d    = 1'b0;
    case (state_d)
      S_EXEC: begin
        aluop_d  = dec_aluop;
        asrc_d   = dec_alusrc;
        branch_d = dec_branch;
        rw_d     = !dec_branch;
        pc_d     = 1'b1;
      end
      S_ILL: begin
        ill_d = 1'b1;
        pc_d  = 1'b1;
      end
      S_MUL: begin
        aluop_d = OPWIDTH'(8);
        rw_d    = (cnt_d == '0);
        pc_d    = (cnt_d == '0);
      end
      S_MEM: begin
        req_d   = 1'b1;
        aluop_d = dec_aluop;
        asrc_d  = dec_alusrc;
        mw_d    = dec_store;
      end
      S_WB: begin
        m2r_d = 1'b1;
        rw_d  = 1'b1;
        pc_d  = 1'b1;
      end
      S_ABORT: begin
        err_d = 1'b1;
        pc_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ir_q     <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      req_q    <= 1'b0;
      branch_q <= 1'b0;
      m2r_q    <= 1'b0;
      mw_q     <= 1'b0;
      asrc_q   <= 1'b0;
      rw_q     <= 1'b0;
      aluop_q  <= '1;
      pc_q     <= 1'b0;
      ill_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      req_q    <= req_d;
      branch_q <= branch_d;
      m2r_q    <= m2r_d;
      mw_q     <= mw_d;
      asrc_q   <= asrc_d;
      rw_q     <= rw_d;
      aluop_q  <= aluop_d;
      pc_q     <= pc_d;
      ill_q    <= ill_d;
      err_q    <= err_d;
    end
  end

  // A store retires in the MEM cycle whose ack completes it, hence the ack term
  assign pc_en       = pc_q | ((state_q == S_MEM) && dec_store && mem_ack);
  assign instr_ready = ready_q;
  assign mem_req     = req_q;
  assign RegDst      = 1'b0;
  assign Branch      = branch_q;
  assign MemtoReg    = m2r_q;
  assign MemWrite    = mw_q;
  assign ALUSrc      = asrc_q;
  assign RegWrite    = rw_q;
  assign ALUOp       = aluop_q;
  assign illegal_op  = ill_q;
  assign mem_err     = err_q;

endmodule
